ctmm_msave_sched: RTL and testbench

Round-robin scheduler that shares the single trusted mSave micro-routine between NUM_REQ requesters (port 0 = SAVE instruction, port 1 = CHANGE context switch, others spare).
- Accepts one save request at a time and sequences the mSave start/done/fault handshake.
- Routes completion or fault back to the owning requester.
- Supports locked bursts so CHANGE can save a full context without interleaving.
- Adds a watchdog on the mSave interface.

---
 rtl/ctmm_pkg.sv | 34 +++
 rtl/ctmm_msave_sched_if.sv | 26 ++
 rtl/ctmm_rr_arbiter.sv | 35 +++
 rtl/ctmm_msave_sched.sv | 150 +++++++++++++++
 tb/tb_ctmm_msave_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctmm_pkg.sv
// Shared types for the CTMM capability machine.
// Fault codes, capability register layout and the mSave request bundle.
package ctmm_pkg;

  typedef enum logic [2:0] {
    FAULT_NONE    = 3'd0,
    FAULT_PERM    = 3'd1,
    FAULT_BOUNDS  = 3'd2,
    FAULT_TYPE    = 3'd3,
    FAULT_TIMEOUT = 3'd4
  } fault_type_t;

  typedef struct packed {
    logic [31:0] base;
    logic [15:0] length;
    logic [7:0]  perms;
    logic [7:0]  otype;
  } capability_reg_t;

  typedef struct packed {
    capability_reg_t dst_cap;
    logic [63:0]     src_gt;
    logic [7:0]      index;
    logic            lock;
  } msave_req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/ctmm_msave_sched_if.sv
// Handshake and operand bundle between the scheduler and the mSave routine.
// master = scheduler side, slave = mSave side.
interface ctmm_msave_sched_if
  import ctmm_pkg::*;
();

  logic            ms_start;
  capability_reg_t ms_dst_cap;
  logic [63:0]     ms_src_gt;
  logic [7:0]      ms_index;
  logic            ms_busy;
  logic            ms_done;
  logic            ms_fault;
  fault_type_t     ms_fault_type;

  modport master (
    output ms_start, ms_dst_cap, ms_src_gt, ms_index,
    input  ms_busy, ms_done, ms_fault, ms_fault_type
  );

  modport slave (
    input  ms_start, ms_dst_cap, ms_src_gt, ms_index,
    output ms_busy, ms_done, ms_fault, ms_fault_type
  );

endinterface

// File: rtl/ctmm_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping, returned as a one-hot grant plus its index.
module ctmm_rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id,
  output logic           any
);

  int             s;
  logic [IDW-1:0] k;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    s     = 0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      k = IDW'(s);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        id       = k;
      end
    end
  end

endmodule

// File: rtl/ctmm_msave_sched.sv
// Round-robin scheduler sharing the mSave micro-routine between requesters,
// with locked bursts and an mSave watchdog.
module ctmm_msave_sched
  import ctmm_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  capability_reg_t        req_dst_cap [NUM_REQ],
  input  logic [63:0]            req_src_gt  [NUM_REQ],
  input  logic [7:0]             req_index   [NUM_REQ],
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_done,
  output logic                   rsp_fault,
  output logic [ID_W-1:0]        rsp_id,
  output fault_type_t            rsp_fault_type,
  ctmm_msave_sched_if.master     ms
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_t       state, state_nxt;
  msave_req_t         cur;
  logic [ID_W-1:0]    cur_id;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    lock_owner;
  logic               lock_active;
  logic               res_fault;
  fault_type_t        res_type;
  logic [WD_W-1:0]    wdog;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_gnt;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic               grant_go;
  logic               start;
  logic               wd_expire;

  assign eligible = lock_active
                  ? (req_valid & (NUM_REQ'(1) << lock_owner))
                  : req_valid;

  ctmm_rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (win_gnt),
    .id    (win_id),
    .any   (win_any)
  );

  assign wd_expire     = (wdog == WD_W'(TIMEOUT_CYC - 1));
  assign ms.ms_start   = start;
  assign ms.ms_dst_cap = cur.dst_cap;
  assign ms.ms_src_gt  = cur.src_gt;
  assign ms.ms_index   = cur.index;

  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    grant_go       = 1'b0;
    start          = 1'b0;
    rsp_done       = 1'b0;
    rsp_fault      = 1'b0;
    rsp_id         = '0;
    rsp_fault_type = FAULT_NONE;
    unique case (state)
      S_IDLE: begin
        // rst_n gate keeps the accept pulse quiet while held in reset
        if (win_any && !ms.ms_busy && rst_n) begin
          grant_go  = 1'b1;
          req_ready = win_gnt;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ms.ms_done || ms.ms_fault || wd_expire)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_done       = !res_fault;
        rsp_fault      = res_fault;
        rsp_id         = cur_id;
        rsp_fault_type = res_type;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur         <= '0;
      cur_id      <= '0;
      rr_ptr      <= '0;
      lock_owner  <= '0;
      lock_active <= 1'b0;
      res_fault   <= 1'b0;
      res_type    <= FAULT_NONE;
      wdog        <= '0;
    end else begin
      state <= state_nxt;
      if (grant_go) begin
        cur <= '{dst_cap: req_dst_cap[win_id],
                 src_gt:  req_src_gt[win_id],
                 index:   req_index[win_id],
                 lock:    req_lock[win_id]};
        cur_id <= win_id;
      end
      if (state == S_IDLE && lock_active &&
          !req_valid[lock_owner] && !req_lock[lock_owner])
        lock_active <= 1'b0;
      if (state == S_ISSUE)
        wdog <= '0;
      if (state == S_WAIT) begin
        wdog <= wdog + WD_W'(1);
        // fault outranks a simultaneous done
        if (ms.ms_fault) begin
          res_fault <= 1'b1;
          res_type  <= ms.ms_fault_type;
        end else if (ms.ms_done) begin
          res_fault <= 1'b0;
          res_type  <= FAULT_NONE;
        end else if (wd_expire) begin
          res_fault <= 1'b1;
          res_type  <= FAULT_TIMEOUT;
        end
      end
      if (state == S_RESP) begin
        rr_ptr      <= (cur_id == ID_W'(NUM_REQ - 1))
                     ? '0 : cur_id + ID_W'(1);
        lock_active <= cur.lock && !res_fault;
        lock_owner  <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_ctmm_msave_sched.sv
// Directed testbench for ctmm_msave_sched.
// Each scenario task drives stimulus and checks against hand-derived values.
module tb_ctmm_msave_sched;
  import ctmm_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_lock;
  capability_reg_t req_dst_cap [2];
  logic [63:0]     req_src_gt  [2];
  logic [7:0]      req_index   [2];
  logic [1:0]      req_ready;
  logic            rsp_done;
  logic            rsp_fault;
  logic [0:0]      rsp_id;
  fault_type_t     rsp_fault_type;

  int checks   = 0;
  int failures = 0;

  ctmm_msave_sched_if msif ();

  ctmm_msave_sched #(
    .NUM_REQ     (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_lock       (req_lock),
    .req_dst_cap    (req_dst_cap),
    .req_src_gt     (req_src_gt),
    .req_index      (req_index),
    .req_ready      (req_ready),
    .rsp_done       (rsp_done),
    .rsp_fault      (rsp_fault),
    .rsp_id         (rsp_id),
    .rsp_fault_type (rsp_fault_type),
    .ms             (msif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_wait(output int id, output int waited);
    id     = -1;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        id = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
        tick();
        return;
      end
      waited++;
      tick();
    end
  endtask

  // Called in ISSUE; returns the response seen in RESP and ends in IDLE.
  task automatic serve(input int dur, input bit flt, input fault_type_t ft,
                       output bit d, output bit f, output int rid,
                       output fault_type_t rt);
    msif.ms_busy = 1'b1;
    repeat (dur) tick();
    if (flt) begin
      msif.ms_fault      = 1'b1;
      msif.ms_fault_type = ft;
    end else begin
      msif.ms_done = 1'b1;
    end
    msif.ms_busy = 1'b0;
    tick();
    msif.ms_done       = 1'b0;
    msif.ms_fault      = 1'b0;
    msif.ms_fault_type = FAULT_NONE;
    d   = rsp_done;
    f   = rsp_fault;
    rid = int'(rsp_id);
    rt  = rsp_fault_type;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b01;
    tick();
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b want=00", req_ready); end
    checks++; if (msif.ms_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", msif.ms_start); end
    checks++; if ({rsp_done, rsp_fault} !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b want=00", {rsp_done, rsp_fault}); end
    checks++; if (rsp_fault_type !== FAULT_NONE) begin failures++; $display("FAIL reset_ftype got=%0d want=0", rsp_fault_type); end
    checks++; if (msif.ms_src_gt !== 64'h0 || msif.ms_index !== 8'h0) begin failures++; $display("FAIL reset_operands got=%h/%h want=0/0", msif.ms_src_gt, msif.ms_index); end
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_save();
    capability_reg_t cap;
    cap = '{base: 32'h1000_0000, length: 16'h0400, perms: 8'h3c, otype: 8'h01};
    req_dst_cap[0] = cap;
    req_src_gt[0]  = 64'hdead_beef_0123_4567;
    req_index[0]   = 8'd3;
    req_lock       = 2'b00;
    req_valid      = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b want=01", req_ready); end
    checks++; if (msif.ms_start !== 1'b0) begin failures++; $display("FAIL single_start_early got=%b want=0", msif.ms_start); end
    tick();
    req_valid = 2'b00;
    checks++; if (msif.ms_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b want=1", msif.ms_start); end
    checks++; if (msif.ms_index !== 8'd3) begin failures++; $display("FAIL single_index got=%0d want=3", msif.ms_index); end
    checks++; if (msif.ms_src_gt !== 64'hdead_beef_0123_4567) begin failures++; $display("FAIL single_gt got=%h want=deadbeef01234567", msif.ms_src_gt); end
    checks++; if (msif.ms_dst_cap !== cap) begin failures++; $display("FAIL single_cap got=%h want=%h", msif.ms_dst_cap, cap); end
    msif.ms_busy = 1'b1;
    req_index[0] = 8'd99;
    repeat (4) tick();
    checks++; if (msif.ms_start !== 1'b0 || msif.ms_index !== 8'd3) begin failures++; $display("FAIL single_hold got=%b/%0d want=0/3", msif.ms_start, msif.ms_index); end
    msif.ms_done = 1'b1;
    msif.ms_busy = 1'b0;
    #1;
    checks++; if (rsp_done !== 1'b0) begin failures++; $display("FAIL single_done_early got=%b want=0", rsp_done); end
    tick();
    msif.ms_done = 1'b0;
    checks++; if (rsp_done !== 1'b1 || rsp_fault !== 1'b0) begin failures++; $display("FAIL single_done got=%b%b want=10", rsp_done, rsp_fault); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL single_id got=%0d want=0", rsp_id); end
    tick();
    checks++; if (rsp_done !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b want=0", rsp_done); end
  endtask

  task automatic test_alternate();
    int exp_id [4] = '{1, 0, 1, 0};
    int id, waited, rid;
    bit d, f;
    fault_type_t rt;
    req_lock  = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      grant_wait(id, waited);
      checks++; if (id !== exp_id[k]) begin failures++; $display("FAIL alt_grant%0d got=%0d want=%0d", k, id, exp_id[k]); end
      if (k > 0) begin
        checks++; if (waited !== 0) begin failures++; $display("FAIL alt_gap%0d got=%0d want=0", k, waited); end
      end
      serve(2, 1'b0, FAULT_NONE, d, f, rid, rt);
      checks++; if (d !== 1'b1 || rid !== exp_id[k]) begin failures++; $display("FAIL alt_rsp%0d got=%b/%0d want=1/%0d", k, d, rid, exp_id[k]); end
    end
  endtask

  task automatic test_burst();
    bit lk [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int exp_id [5] = '{1, 1, 1, 1, 0};
    int id, waited, rid;
    bit d, f;
    fault_type_t rt;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      req_lock = {lk[k], 1'b0};
      grant_wait(id, waited);
      checks++; if (id !== exp_id[k]) begin failures++; $display("FAIL burst_grant%0d got=%0d want=%0d", k, id, exp_id[k]); end
      serve(1, 1'b0, FAULT_NONE, d, f, rid, rt);
      checks++; if (d !== 1'b1 || rid !== exp_id[k]) begin failures++; $display("FAIL burst_rsp%0d got=%b/%0d want=1/%0d", k, d, rid, exp_id[k]); end
    end
  endtask

  task automatic test_burst_fault();
    int id, waited, rid;
    bit d, f;
    fault_type_t rt;
    req_valid = 2'b11;
    req_lock  = 2'b10;
    grant_wait(id, waited);
    checks++; if (id !== 1) begin failures++; $display("FAIL bf_grant0 got=%0d want=1", id); end
    serve(1, 1'b0, FAULT_NONE, d, f, rid, rt);
    grant_wait(id, waited);
    checks++; if (id !== 1) begin failures++; $display("FAIL bf_grant1 got=%0d want=1", id); end
    serve(3, 1'b1, FAULT_PERM, d, f, rid, rt);
    checks++; if (f !== 1'b1 || d !== 1'b0) begin failures++; $display("FAIL bf_fault got=%b%b want=01", d, f); end
    checks++; if (rid !== 1) begin failures++; $display("FAIL bf_id got=%0d want=1", rid); end
    checks++; if (rt !== FAULT_PERM) begin failures++; $display("FAIL bf_type got=%0d want=%0d", rt, FAULT_PERM); end
    grant_wait(id, waited);
    checks++; if (id !== 0) begin failures++; $display("FAIL bf_release got=%0d want=0", id); end
    serve(1, 1'b0, FAULT_NONE, d, f, rid, rt);
    req_valid = 2'b00;
    req_lock  = 2'b00;
  endtask

  task automatic test_timeout();
    int id, waited, rid, n;
    bit d, f;
    fault_type_t rt;
    req_valid = 2'b01;
    grant_wait(id, waited);
    checks++; if (id !== 0) begin failures++; $display("FAIL to_grant got=%0d want=0", id); end
    checks++; if (msif.ms_start !== 1'b1) begin failures++; $display("FAIL to_start got=%b want=1", msif.ms_start); end
    msif.ms_busy = 1'b1;
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (rsp_fault === 1'b1 || rsp_done === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 65) begin failures++; $display("FAIL to_latency got=%0d want=65", n); end
    checks++; if (rsp_fault !== 1'b1 || rsp_fault_type !== FAULT_TIMEOUT) begin failures++; $display("FAIL to_fault got=%b/%0d want=1/%0d", rsp_fault, rsp_fault_type, FAULT_TIMEOUT); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL to_id got=%0d want=0", rsp_id); end
    tick();
    repeat (3) begin
      tick();
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL to_blocked got=%b want=00", req_ready); end
    end
    msif.ms_done = 1'b1;
    tick();
    msif.ms_done = 1'b0;
    checks++; if (rsp_done !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL to_late_done got=%b/%b want=0/00", rsp_done, req_ready); end
    msif.ms_busy = 1'b0;
    grant_wait(id, waited);
    checks++; if (id !== 0 || waited !== 0) begin failures++; $display("FAIL to_regrant got=%0d/%0d want=0/0", id, waited); end
    serve(2, 1'b0, FAULT_NONE, d, f, rid, rt);
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL to_after got=%b want=1", d); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    int id, waited, rid, seen;
    bit d, f;
    fault_type_t rt;
    req_index[0] = 8'd7;
    req_valid = 2'b01;
    grant_wait(id, waited);
    checks++; if (id !== 0) begin failures++; $display("FAIL rm_grant got=%0d want=0", id); end
    msif.ms_busy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (msif.ms_start !== 1'b0 || msif.ms_index !== 8'd0 || msif.ms_src_gt !== 64'h0) begin failures++; $display("FAIL rm_ms_zero got=%b/%0d/%h want=0/0/0", msif.ms_start, msif.ms_index, msif.ms_src_gt); end
    checks++; if (req_ready !== 2'b00 || rsp_done !== 1'b0 || rsp_fault !== 1'b0) begin failures++; $display("FAIL rm_out_zero got=%b/%b/%b want=00/0/0", req_ready, rsp_done, rsp_fault); end
    tick();
    req_valid = 2'b00;
    msif.ms_busy = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (rsp_done === 1'b1 || rsp_fault === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rm_no_rsp got=%0d want=0", seen); end
    req_valid = 2'b10;
    grant_wait(id, waited);
    checks++; if (id !== 1 || waited !== 0) begin failures++; $display("FAIL rm_regrant got=%0d/%0d want=1/0", id, waited); end
    req_valid = 2'b00;
    serve(2, 1'b0, FAULT_NONE, d, f, rid, rt);
    checks++; if (d !== 1'b1 || rid !== 1) begin failures++; $display("FAIL rm_rsp got=%b/%0d want=1/1", d, rid); end
  endtask

  initial begin
    rst_n              = 1'b0;
    req_valid          = 2'b00;
    req_lock           = 2'b00;
    msif.ms_busy       = 1'b0;
    msif.ms_done       = 1'b0;
    msif.ms_fault      = 1'b0;
    msif.ms_fault_type = FAULT_NONE;
    for (int i = 0; i < 2; i++) begin
      req_dst_cap[i] = '{base: 32'(i) << 20, length: 16'h0100, perms: 8'h0f, otype: 8'(i)};
      req_src_gt[i]  = 64'h1111_0000_0000_0000 + 64'(i);
      req_index[i]   = 8'(i + 10);
    end
    test_reset();
    test_single_save();
    test_alternate();
    test_burst();
    test_burst_fault();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
